// File: rtl/spi_xfer_arbiter_pkg.sv
// Purpose: shared constants and types for the SPI transfer arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: frame width, FSM state encodings, {CKP,CPH} mode bit positions.
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GRANT     = 3'd1;
  localparam logic [2:0] ST_STRT      = 3'd2;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_GAP       = 3'd6;

  // Bit positions inside each requester's 2-bit mode field.
  localparam int MODE_CPH = 0;
  localparam int MODE_CKP = 1;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_GRANT     = ST_GRANT,
    S_STRT      = ST_STRT,
    S_WAIT_LOW  = ST_WAIT_LOW,
    S_WAIT_HIGH = ST_WAIT_HIGH,
    S_DONE      = ST_DONE,
    S_GAP       = ST_GAP
  } state_t;

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Purpose: bundle of signals between the arbiter and the shared SPI master.
// Latency: n/a (wires only).
// Backpressure: none; CS level from the master paces the arbiter.
// Signals: spi_strt/spi_data_in/spi_cph/spi_ckp toward the master,
//          spi_cs (active-low) and spi_rx_data back from it.
interface spi_xfer_arbiter_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
);
  logic              spi_strt;
  logic [DATA_W-1:0] spi_data_in;
  logic              spi_cph;
  logic              spi_ckp;
  logic              spi_cs;
  logic [DATA_W-1:0] spi_rx_data;

  // Arbiter side.
  modport master (
    output spi_strt, spi_data_in, spi_cph, spi_ckp,
    input  spi_cs, spi_rx_data
  );

  // SPI master side.
  modport slave (
    input  spi_strt, spi_data_in, spi_cph, spi_ckp,
    output spi_cs, spi_rx_data
  );
endinterface

// File: rtl/spi_rr_pick.sv
// Purpose: combinational round-robin pick, first asserted req at or after ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; win_oh is all-zero when req is all-zero.
// Ports: req (request vector), ptr (search start), win_oh (one-hot), win_idx.
module spi_rr_pick
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;
    sum     = '0;
    cand    = '0;
    found   = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr + i folded back into 0..NUM_REQ-1 without a divider.
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_oh[win_idx] = found;
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Purpose: round-robin share of one SPI master among NUM_REQ requesters.
// Latency: grant 1 clk after req seen in IDLE; strobe 1 clk after grant; done 1 clk after CS rises.
// Backpressure: req is a level held until done; requests arriving while busy wait, none dropped.
// Ports: clk/rst (sync, active-high), req/req_data/req_mode in, gnt/done/err/rx_data/busy out,
//        spi (master modport of spi_xfer_arbiter_if) toward the SPI master.
// Optional: SPI_ARB_TIMEOUT_EN adds a CS watchdog of TIMEOUT_CYCLES; otherwise err is tied 0.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = SPI_DATA_W,
  parameter int STRT_CYCLES    = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_mode,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      done,
  output logic                      err,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  spi_xfer_arbiter_if.master        spi
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > STRT_CYCLES) ?
                           ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES) :
                           ((STRT_CYCLES > GAP_CYCLES) ? STRT_CYCLES : GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STRT_LAST = CNT_W'(STRT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               latch_en;
  logic               cap_en;
  logic               release_en;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [DATA_W-1:0]  sel_data;
  logic [1:0]         sel_mode;

  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   widx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [DATA_W-1:0]  data_q;
  logic               cph_q;
  logic               ckp_q;
  logic [DATA_W-1:0]  rx_q;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_mode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_mode = req_mode[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic err_nxt;
  logic err_q;
`endif

  // The counter is shared: STRT width, CS watchdog, and GAP length never overlap.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    latch_en   = 1'b0;
    cap_en     = 1'b0;
    release_en = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    err_nxt    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (|req) begin
          latch_en  = 1'b1;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_nxt   = '0;
        state_nxt = S_STRT;
      end
      S_STRT: begin
        if (cnt == STRT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_LOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_LOW: begin
        // Needs a low level observed after the strobe, so a stale low in IDLE is harmless.
        if (!spi.spi_cs) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_HIGH;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
          cnt_nxt    = '0;
          release_en = 1'b1;
          err_nxt    = 1'b1;
          state_nxt  = S_GAP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      S_WAIT_HIGH: begin
        if (spi.spi_cs) begin
          cap_en    = 1'b1;
          state_nxt = S_DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
          cnt_nxt    = '0;
          release_en = 1'b1;
          err_nxt    = 1'b1;
          state_nxt  = S_GAP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      S_DONE: begin
        release_en = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Config registers load only on a grant, so they cannot move under a low CS.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= '0;
      widx_q <= '0;
      ptr_q  <= '0;
      data_q <= '0;
      cph_q  <= 1'b0;
      ckp_q  <= 1'b0;
      rx_q   <= '0;
    end else begin
      if (latch_en) begin
        gnt_q  <= win_oh;
        widx_q <= win_idx;
        data_q <= sel_data;
        cph_q  <= sel_mode[MODE_CPH];
        ckp_q  <= sel_mode[MODE_CKP];
      end
      if (cap_en) begin
        rx_q <= spi.spi_rx_data;
      end
      if (release_en) begin
        gnt_q <= '0;
        ptr_q <= (widx_q == IDX_W'(NUM_REQ - 1)) ? '0 : widx_q + 1'b1;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nxt;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt             = gnt_q;
  assign done            = (state == S_DONE);
  assign busy            = (state != S_IDLE);
  assign rx_data         = rx_q;
  assign spi.spi_strt    = (state == S_STRT);
  assign spi.spi_data_in = data_q;
  assign spi.spi_cph     = cph_q;
  assign spi.spi_ckp     = ckp_q;

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Round-robin arbiter and sequencer that shares one transmitter_SPI master among NUM_REQ requesters. Each requester supplies a 16-bit word and its SPI mode (CPH/CKP). The block latches the winning request, drives the master's configuration and start strobe, and tracks CS through the frame. When the frame ends it returns the received word and a one-cycle done pulse to the winner. It sits between system logic and the SPI master/slave chain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, SPI frame width
STRT_CYCLES, 2, width of the spi_strt pulse in clk cycles (>=1)
GAP_CYCLES, 4, idle clk cycles forced between frames (CS high time, >=1)
TIMEOUT_CYCLES, 1023, watchdog limit used only when SPI_ARB_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester transfer request, level; held until done
req_data  in  NUM_REQ*DATA_W  packed TX words, requester i at [i*DATA_W +: DATA_W]
req_mode  in  NUM_REQ*2  packed {CKP,CPH} per requester, i at [i*2 +: 2]
gnt  out  NUM_REQ  one-hot grant, held from latch until done
done  out  1  one-cycle pulse when the granted frame completes
err  out  1  one-cycle pulse on watchdog abort (tied 0 without the optional feature)
rx_data  out  DATA_W  word received in the last frame, valid when done=1, then held
busy  out  1  high from grant until the gap ends
spi_strt  out  1  start strobe to the master
spi_data_in  out  DATA_W  TX word to the master
spi_cph  out  1  CPH to the master and slaves
spi_ckp  out  1  CKP to the master and slaves
spi_cs  in  1  CS from the master, active-low, low during the frame
spi_rx_data  in  DATA_W  master's received shift register, stable once CS rises

Behaviour:
- Reset: the arbiter is in IDLE. gnt=0, done=0, err=0, busy=0, spi_strt=0, rx_data=0, spi_data_in=0, spi_cph=0, spi_ckp=0. The round-robin pointer is 0. Reset mid-frame aborts immediately with no done pulse. The master is reset separately.
- State machine: IDLE -> GRANT -> STRT -> WAIT_LOW -> WAIT_HIGH -> DONE -> GAP -> IDLE.
- IDLE: if req!=0, pick the first asserted requester starting at the pointer, wrapping modulo NUM_REQ. Register gnt, spi_data_in, spi_cph and spi_ckp from that requester, and set busy=1. Next state is GRANT.
- GRANT: one cycle so that configuration settles before the strobe. Next state is STRT.
- STRT: spi_strt=1 for exactly STRT_CYCLES cycles. Next state is WAIT_LOW.
- WAIT_LOW: wait for spi_cs=0. Next state is WAIT_HIGH.
- WAIT_HIGH: wait for spi_cs=1 (rising edge of CS). On that edge, capture spi_rx_data into rx_data. Next state is DONE.
- DONE: done=1 for one cycle and gnt is cleared. The pointer advances to (winner+1) mod NUM_REQ. Next state is GAP.
- GAP: a counter runs GAP_CYCLES cycles, then busy=0 and the state returns to IDLE. Arbitration happens at the earliest on the next cycle. Minimum spacing between spi_strt rising edges is therefore 1 + 1 + STRT_CYCLES + frame length + 1 + GAP_CYCLES.
- spi_data_in, spi_cph and spi_ckp are held constant from GRANT until the next grant. They never change while spi_cs=0.
- A requester that deasserts req mid-frame does not abort it. The frame completes and done still pulses.
- req or req_data changes after the latch are ignored until the next arbitration.
- If a single requester is held continuously, it is re-granted after each gap.
- Requests arriving while busy=1 wait; none are lost while req is held.
- If spi_cs is already 0 in IDLE, arbitration is not blocked. WAIT_LOW then requires a fresh low level.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined: a counter runs in WAIT_LOW and WAIT_HIGH. After TIMEOUT_CYCLES cycles without the awaited CS level, the state goes to GAP with err=1 for one cycle. done is not pulsed, rx_data is unchanged, gnt is cleared, and the pointer advances.
- Undefined: no counter is present, err is tied to 0, and the arbiter may wait forever.

Decomposition:
- Shared package spi_pkg: SPI_DATA_W=16, the state-encoding localparams (IDLE..GAP, 3 bits), and the mode bit indices (MODE_CPH=0, MODE_CKP=1).
- One sub-module, spi_rr_pick. It is combinational: inputs req and pointer, outputs one-hot winner and winner index. It keeps the FSM file focused on sequencing.

Test Plan:
1. Reset: hold rst=1 while req=4'b1111 -> all outputs 0 and no spi_strt. Release rst -> gnt=4'b0001 two cycles later.
2. Single request: req[2]=1, data 16'h5555, mode {CKP=1,CPH=0} -> gnt=4'b0100, spi_ckp=1, spi_cph=0, and spi_strt high exactly 2 cycles. Slave chain returns 16'h0F0F -> rx_data=16'h0F0F with one done pulse.
3. Fairness: req=4'b1111 held, each with a distinct data word -> grant order 0,1,2,3,0. spi_data_in matches each requester's word, and the gap between frames is >=4 cycles with CS high.
4. Mode switching: req0 mode 2'b00, req1 mode 2'b11 -> spi_cph and spi_ckp change only outside CS-low windows, and each frame is received correctly by both slaves.
5. Reset mid-frame: pulse rst while spi_cs=0 -> next cycle gnt=0, busy=0, done never pulses, and the pointer is back at 0.
6. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20: hold the master in reset so CS stays high -> err pulses once, 20 cycles after STRT ends. done stays 0 and the next requester is granted after the gap.
